// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the 4-state sequence FSM: synchronises raw x/z, debounces them as a
// pair and commits both bits on one edge with a single-cycle pair_valid strobe.
module fsm_input_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic x_raw,
    input  logic z_raw,
    output logic x,
    output logic z,
    output logic pair_valid,
    output logic stable
);

    localparam logic [0:0] StStable   = 1'b0;
    localparam logic [0:0] StSettling = 1'b1;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    // Bit 1 carries x, bit 0 carries z throughout.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       last_q, last_d;
    logic [1:0]       out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             pv_q, pv_d;

    // Synchroniser runs independently of en so a later enable sees settled data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {x_raw, z_raw};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        pv_d    = 1'b0;
        if (en) begin
            case (state_q)
                StStable: begin
                    if (sync2_q != last_q) begin
                        last_d  = sync2_q;
                        cnt_d   = '0;
                        state_d = StSettling;
                    end
                end
                StSettling: begin
                    if (sync2_q != last_q) begin
                        last_d = sync2_q;
                        cnt_d  = '0;
                    end else if (cnt_q < CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = StStable;
                        // A candidate that returned to the committed pair settles silently.
                        if (last_q != out_q) begin
                            out_d = last_q;
                            pv_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StStable;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StStable;
            last_q  <= 2'b00;
            cnt_q   <= '0;
            out_q   <= 2'b00;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            pv_q    <= pv_d;
        end
    end

    assign x          = out_q[1];
    assign z          = out_q[0];
    assign pair_valid = pv_q;
    assign stable     = (state_q == StStable);

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Bench for fsm_input_conditioner: directed scenarios plus random stimulus, with DB_CYCLES=4 and
// DB_CYCLES=1 instances compared against a run-length model of the debounce rule.
module tb_fsm_input_conditioner;

    localparam int unsigned DB0 = 4;
    localparam int unsigned DB1 = 1;

    logic       clk = 1'b0;
    logic       rst, en, x_raw, z_raw;
    logic [1:0] x_o, z_o, pv_o, st_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: two-edge delay of the raw pair, then per-instance pending/candidate/run length.
    logic [1:0] m_d1, m_d2;
    logic [1:0] m_out  [2];
    logic [1:0] m_cand [2];
    bit         m_pend [2];
    bit         m_pv   [2];
    int         m_len  [2];
    int         db     [2];

    fsm_input_conditioner #(.DB_CYCLES(DB0), .CNT_W(3)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x_raw      (x_raw),
        .z_raw      (z_raw),
        .x          (x_o[0]),
        .z          (z_o[0]),
        .pair_valid (pv_o[0]),
        .stable     (st_o[0])
    );

    fsm_input_conditioner #(.DB_CYCLES(DB1), .CNT_W(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x_raw      (x_raw),
        .z_raw      (z_raw),
        .x          (x_o[1]),
        .z          (z_o[1]),
        .pair_valid (pv_o[1]),
        .stable     (st_o[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = 2'b00;
        m_d2 = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_out[i]  = 2'b00;
            m_cand[i] = 2'b00;
            m_pend[i] = 1'b0;
            m_pv[i]   = 1'b0;
            m_len[i]  = 0;
        end
    endtask

    // A new pair must be seen on DB+1 consecutive enabled edges before it becomes the output.
    task automatic model_sample(input int i, input logic [1:0] v);
        if (!m_pend[i]) begin
            if (v != m_out[i]) begin
                m_pend[i] = 1'b1;
                m_cand[i] = v;
                m_len[i]  = 1;
            end
        end else begin
            if (v == m_cand[i]) begin
                m_len[i]++;
            end else begin
                m_cand[i] = v;
                m_len[i]  = 1;
            end
            if (m_len[i] == db[i] + 1) begin
                m_pend[i] = 1'b0;
                if (m_cand[i] != m_out[i]) begin
                    m_out[i] = m_cand[i];
                    m_pv[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("x[%0d]", i), x_o[i], m_out[i][1]);
            chk($sformatf("z[%0d]", i), z_o[i], m_out[i][0]);
            chk($sformatf("pair_valid[%0d]", i), pv_o[i], m_pv[i]);
            chk($sformatf("stable[%0d]", i), st_o[i], !m_pend[i]);
        end
    endtask

    task automatic step();
        logic [1:0] v;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            v    = m_d2;
            m_d2 = m_d1;
            m_d1 = {x_raw, z_raw};
            for (int i = 0; i < 2; i++) begin
                m_pv[i] = 1'b0;
                if (en) model_sample(i, v);
            end
        end
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  pulses;
        int  pulse_edge;
        bit  seen10;
        bit  seen_low;
        bit  seen_pv;
        bit  moved;

        db[0] = DB0;
        db[1] = DB1;
        rst   = 1'b0;
        en    = 1'b1;
        x_raw = 1'b1;
        z_raw = 1'b1;

        // Reset asserted mid-cycle with raw inputs high.
        #7;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_x", x_o[0], 1'b0);
        chk("rst_async_z", z_o[0], 1'b0);
        chk("rst_async_pv", pv_o[0], 1'b0);
        chk("rst_async_stable", st_o[0], 1'b1);
        step();
        step();
        x_raw = 1'b0;
        z_raw = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("rst_quiet_x", x_o[0], 1'b0);
        chk("rst_quiet_stable", st_o[0], 1'b1);

        // Clean z change: SETTLING after edge 2, commit after edge 6.
        z_raw = 1'b1;
        step();
        step();
        chk("clean_stable_e1", st_o[0], 1'b1);
        step();
        chk("clean_stable_e2", st_o[0], 1'b0);
        step();
        step();
        step();
        chk("clean_pv_e5", pv_o[0], 1'b0);
        chk("clean_z_e5", z_o[0], 1'b0);
        step();
        chk("clean_pv_e6", pv_o[0], 1'b1);
        chk("clean_z_e6", z_o[0], 1'b1);
        chk("clean_x_e6", x_o[0], 1'b0);
        step();
        chk("clean_pv_e7", pv_o[0], 1'b0);
        chk("clean_stable_e7", st_o[0], 1'b1);

        // Two-cycle glitch on x must not commit.
        seen_low = 1'b0;
        seen_pv  = 1'b0;
        x_raw    = 1'b1;
        step();
        step();
        x_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (!st_o[0]) seen_low = 1'b1;
            if (pv_o[0]) seen_pv = 1'b1;
        end
        chk("glitch_stable_dropped", seen_low, 1'b1);
        chk("glitch_no_pulse", seen_pv, 1'b0);
        chk("glitch_x_low", x_o[0], 1'b0);
        chk("glitch_stable_back", st_o[0], 1'b1);

        // Skewed pair: x at edge 0, z at edge 1, single commit of 11 at edge 7.
        z_raw = 1'b0;
        async_reset_pulse();
        for (int k = 0; k < 5; k++) step();
        x_raw      = 1'b1;
        step();
        z_raw      = 1'b1;
        pulses     = 0;
        pulse_edge = -1;
        seen10     = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (pv_o[0]) begin
                pulses++;
                pulse_edge = e;
            end
            if (x_o[0] && !z_o[0]) seen10 = 1'b1;
        end
        chk("skew_one_pulse", (pulses == 1), 1'b1);
        chk("skew_pulse_edge7", (pulse_edge == 7), 1'b1);
        chk("skew_never_10", seen10, 1'b0);
        chk("skew_x", x_o[0], 1'b1);
        chk("skew_z", z_o[0], 1'b1);

        // Reset in the middle of settling discards the candidate.
        x_raw = 1'b0;
        z_raw = 1'b0;
        async_reset_pulse();
        for (int k = 0; k < 3; k++) step();
        z_raw = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_z", z_o[0], 1'b0);
        chk("midrst_pv", pv_o[0], 1'b0);
        chk("midrst_stable", st_o[0], 1'b1);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("midrst_z_e5", z_o[0], 1'b0);
        step();
        chk("midrst_z_e6", z_o[0], 1'b1);
        chk("midrst_pv_e6", pv_o[0], 1'b1);

        // Enable low freezes outputs; commit DB_CYCLES+1 edges after en rises.
        en     = 1'b0;
        x_raw  = 1'b1;
        moved  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (x_o[0] || !z_o[0] || pv_o[0]) moved = 1'b1;
        end
        chk("en_hold_static", moved, 1'b0);
        en = 1'b1;
        for (int k = 0; k < DB0; k++) step();
        chk("en_x_before", x_o[0], 1'b0);
        step();
        chk("en_x_commit", x_o[0], 1'b1);
        chk("en_pv_commit", pv_o[0], 1'b1);
        chk("en_z_kept", z_o[0], 1'b1);

        // Random phase: bursty toggling, enable drops and occasional async resets.
        for (int k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            if ((k / 50) % 2 == 0) begin
                if ($urandom_range(0, 2) == 0) x_raw = ~x_raw;
                if ($urandom_range(0, 2) == 0) z_raw = ~z_raw;
            end else begin
                if ($urandom_range(0, 11) == 0) x_raw = ~x_raw;
                if ($urandom_range(0, 11) == 0) z_raw = ~z_raw;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
